// File: rtl/alarm_status_display.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : alarm_status_display                                         |
// | Description : Status LEDs, BCD timer digits and keypad digit for the alarm |
// |               controller. Optional ALERT_HEX_FLASH_EN flashes the hex      |
// |               digits in ALERT in step with the LEDs.                       |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+

package alarm_pkg;
    typedef enum logic [1:0] {
        STATE_IDLE    = 2'd0,
        STATE_SET     = 2'd1,
        STATE_TRIGGER = 2'd2,
        STATE_ALERT   = 2'd3
    } fsm_state_t;
endpackage

module alarm_status_display
    import alarm_pkg::*;
#(
    parameter int NUM_LEDS     = 10,
    parameter int NUM_DIGITS   = 2,
    parameter int TIMER_W      = 8,
    parameter int FLASH_CYCLES = 25_000_000
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  fsm_state_t                   system_state,
    input  logic [TIMER_W-1:0]           timer,
    input  logic [3:0]                   current_value,
    output logic [NUM_LEDS-1:0]          led,
    output logic [NUM_DIGITS-1:0][1:7]   hex_timer,
    output logic [1:7]                   hex_value,
    output logic                         bcd_busy
);

    // Two spare BCD digits hold any overflow beyond NUM_DIGITS for saturation.
    localparam int c_bcd_digits = NUM_DIGITS + 2;
    localparam int c_bcd_w      = c_bcd_digits * 4;
    localparam int c_dd_w       = c_bcd_w + TIMER_W;
    localparam int c_held_w     = NUM_DIGITS * 4;
    localparam int c_cnt_w      = $clog2(TIMER_W + 1);
    localparam int c_flash_w    = $clog2(FLASH_CYCLES);
    localparam logic [c_cnt_w-1:0]   c_shift_last = c_cnt_w'(TIMER_W - 1);
    localparam logic [c_flash_w-1:0] c_flash_last = c_flash_w'(FLASH_CYCLES - 1);
    localparam logic [1:7]           c_blank      = 7'b1111111;

    typedef enum logic [1:0] {
        BCD_IDLE  = 2'd0,
        BCD_SHIFT = 2'd1,
        BCD_DONE  = 2'd2
    } bcd_state_t;

    function automatic logic [6:0] seg7(input logic [3:0] v);
        case (v)
            4'h0: seg7 = 7'b0000001;
            4'h1: seg7 = 7'b1001111;
            4'h2: seg7 = 7'b0010010;
            4'h3: seg7 = 7'b0000110;
            4'h4: seg7 = 7'b1001100;
            4'h5: seg7 = 7'b0100100;
            4'h6: seg7 = 7'b0100000;
            4'h7: seg7 = 7'b0001111;
            4'h8: seg7 = 7'b0000000;
            4'h9: seg7 = 7'b0000100;
            4'hA: seg7 = 7'b0001000;
            4'hB: seg7 = 7'b1100000;
            4'hC: seg7 = 7'b0110001;
            4'hD: seg7 = 7'b1000010;
            4'hE: seg7 = 7'b0110000;
            default: seg7 = 7'b0111000;
        endcase
    endfunction

    bcd_state_t                     bcd_state_q, bcd_state_d;
    logic [TIMER_W-1:0]             last_q, last_d;
    logic [c_dd_w-1:0]              dd_q, dd_d;
    logic [c_cnt_w-1:0]             shift_cnt_q, shift_cnt_d;
    logic [c_held_w-1:0]            held_q, held_d;
    logic [c_flash_w-1:0]           flash_cnt_q, flash_cnt_d;
    logic                           flash_phase_q, flash_phase_d;
    logic [NUM_LEDS-1:0]            led_q, led_d;
    logic [NUM_DIGITS-1:0][1:7]     hex_timer_q, hex_timer_d;
    logic [1:7]                     hex_value_q, hex_value_d;

    logic [c_dd_w-1:0]              w_step;
    logic                           w_sat;
    logic                           w_seen;
    logic [NUM_DIGITS-1:0]          w_show;
    logic [NUM_DIGITS-1:0][1:7]     w_timer_segs;

    // One double-dabble step: add 3 to every digit >= 5, then shift left.
    always_comb begin
        w_step = dd_q;
        for (int d = 0; d < c_bcd_digits; d++) begin
            if (w_step[TIMER_W + 4*d +: 4] >= 4'd5) begin
                w_step[TIMER_W + 4*d +: 4] = w_step[TIMER_W + 4*d +: 4] + 4'd3;
            end
        end
        w_step = w_step << 1;
    end

    assign w_sat = |dd_q[TIMER_W + c_held_w +: 8];

    always_comb begin
        bcd_state_d = bcd_state_q;
        last_d      = last_q;
        dd_d        = dd_q;
        shift_cnt_d = shift_cnt_q;
        held_d      = held_q;
        case (bcd_state_q)
            BCD_IDLE: begin
                if (timer != last_q) begin
                    bcd_state_d = BCD_SHIFT;
                    last_d      = timer;
                    dd_d        = {{c_bcd_w{1'b0}}, timer};
                    shift_cnt_d = '0;
                end
            end
            BCD_SHIFT: begin
                dd_d        = w_step;
                shift_cnt_d = shift_cnt_q + 1'b1;
                if (shift_cnt_q == c_shift_last) begin
                    bcd_state_d = BCD_DONE;
                end
            end
            BCD_DONE: begin
                held_d      = w_sat ? {NUM_DIGITS{4'd9}} : dd_q[TIMER_W +: c_held_w];
                bcd_state_d = BCD_IDLE;
            end
            default: bcd_state_d = BCD_IDLE;
        endcase
    end

    always_comb begin
        flash_cnt_d   = '0;
        flash_phase_d = 1'b1;
        if (system_state == STATE_ALERT) begin
            flash_phase_d = flash_phase_q;
            if (flash_cnt_q == c_flash_last) begin
                flash_cnt_d   = '0;
                flash_phase_d = ~flash_phase_q;
            end else begin
                flash_cnt_d = flash_cnt_q + 1'b1;
            end
        end
    end

    // Leading-zero blanking: a digit shows once any digit at or above it is nonzero.
    always_comb begin
        w_seen       = 1'b0;
        w_show       = '0;
        w_timer_segs = '1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            w_seen          = w_seen | (held_q[4*i +: 4] != 4'd0);
            w_show[i]       = w_seen | (i == 0);
            w_timer_segs[i] = w_show[i] ? seg7(held_q[4*i +: 4]) : c_blank;
        end
    end

    always_comb begin
        led_d       = '0;
        hex_timer_d = '1;
        hex_value_d = seg7(current_value);
        case (system_state)
            STATE_SET: begin
                for (int i = 0; i < NUM_LEDS; i++) begin
                    led_d[i] = ((i % 2) == 0);
                end
            end
            STATE_TRIGGER: begin
                led_d       = '1;
                hex_timer_d = w_timer_segs;
            end
            STATE_ALERT: begin
                led_d = {NUM_LEDS{flash_phase_q}};
`ifdef ALERT_HEX_FLASH_EN
                if (flash_phase_q) begin
                    hex_timer_d = w_timer_segs;
                end else begin
                    hex_value_d = c_blank;
                end
`endif
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcd_state_q   <= BCD_IDLE;
            last_q        <= '0;
            dd_q          <= '0;
            shift_cnt_q   <= '0;
            held_q        <= '0;
            flash_cnt_q   <= '0;
            flash_phase_q <= 1'b1;
            led_q         <= '0;
            hex_timer_q   <= '1;
            hex_value_q   <= c_blank;
        end else begin
            bcd_state_q   <= bcd_state_d;
            last_q        <= last_d;
            dd_q          <= dd_d;
            shift_cnt_q   <= shift_cnt_d;
            held_q        <= held_d;
            flash_cnt_q   <= flash_cnt_d;
            flash_phase_q <= flash_phase_d;
            led_q         <= led_d;
            hex_timer_q   <= hex_timer_d;
            hex_value_q   <= hex_value_d;
        end
    end

    assign led       = led_q;
    assign hex_timer = hex_timer_q;
    assign hex_value = hex_value_q;
    assign bcd_busy  = (bcd_state_q != BCD_IDLE);

endmodule

`default_nettype wire

// File: doc/alarm_status_display.md
# alarm_status_display

Parametrised status display driver for the alarm controller, successor to the fixed two-digit timer display. Drives NUM_LEDS status LEDs with a per-state pattern (flashing in ALERT), shows the countdown timer on NUM_DIGITS seven-segment digits with leading-zero blanking, and shows the current keypad nibble on one more digit. An internal iterative binary-to-BCD converter replaces the combinational digit splitter, so TIMER_W and NUM_DIGITS scale freely.

## Interface
- NUM_LEDS, 10: status LED count (≥2).
- NUM_DIGITS, 2: timer digits (1..8).
- TIMER_W, 8: timer input width; must satisfy 2^TIMER_W ≤ 10^NUM_DIGITS·16.
- FLASH_CYCLES, 25_000_000: clk cycles per ALERT flash half-period (≥2).
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- system_state  in  fsm_state_t  controller state (STATE_IDLE/SET/TRIGGER/ALERT).
- timer  in  TIMER_W  unsigned countdown value, binary.
- current_value  in  4  keypad nibble, shown as hex 0-F.
- led  out  NUM_LEDS  status LEDs, active-high.
- hex_timer  out  NUM_DIGITS×7  timer digits, index 0 = ones; segments [1:7] = a..g, active-low.
- hex_value  out  7  keypad digit, active-low.
- bcd_busy  out  1  converter running (debug/verification visibility).

## Operation
- All outputs registered. Reset: led = 0, hex_timer all 1111111 (blank), hex_value = 1111111, bcd_busy = 0, flash counter 0, flash phase = on, held BCD = 0.
- LED pattern by state: IDLE all 0; SET alternating, bit0 = 1 (…0101); TRIGGER all 1; ALERT all-on/all-off per flash phase.
- Flash: counter 0..FLASH_CYCLES−1 runs only in ALERT; at terminal count wraps to 0 and phase toggles. Any cycle not in ALERT forces counter 0, phase on; entering ALERT always starts with LEDs on for a full FLASH_CYCLES.
- BCD converter FSM: IDLE → SHIFT (TIMER_W cycles, shift-add-3 double-dabble) → DONE (1 cycle, copies result to held BCD) → IDLE. Starts from IDLE when timer ≠ last-converted value; operand captured at start. Timer change during SHIFT is ignored until DONE, then re-triggers. bcd_busy = 1 in SHIFT and DONE.
- Saturation: if captured value > 10^NUM_DIGITS − 1, held BCD is all 9s.
- hex_timer: in TRIGGER shows held BCD, digits above the most significant nonzero digit blank, digit 0 always shown (0 displays "0"). Outside TRIGGER all blank. Held BCD updates atomically; no mixed old/new digits.
- hex_value: decodes current_value 0-F in every state including IDLE.

## Timing
- State change → led / hex blanking change: 1 cycle.
- current_value change → hex_value: 1 cycle.
- timer change (converter idle) → hex_timer: TIMER_W + 3 cycles (detect, TIMER_W shifts, DONE, output reg).
- Worst case (change just after start): 2·(TIMER_W + 2) + 1 cycles.
- ALERT LED toggle every FLASH_CYCLES cycles exactly; first toggle FLASH_CYCLES cycles after the first ALERT cycle.
- rst_n assertion mid-conversion aborts immediately to reset values; after release a conversion of the present timer starts on the first clk edge (last-converted register resets to 0; timer = 0 needs no conversion).

## Configuration
- ALERT_HEX_FLASH_EN defined: in ALERT, hex_timer shows held BCD (with blanking) during phase on and is blank during phase off, hex_value likewise flashes; synchronised to the LED phase.
- Undefined: hex_timer blank in ALERT, hex_value steady; LED flash unaffected.

## Test plan
- Reset held, then released in IDLE with current_value = 4'hA → led = 0, hex_timer blank, hex_value = 0001000 ("A") one cycle after first edge.
- TRIGGER, timer = 8'd7 (defaults) → after 11 cycles hex_timer[0] = 0001111 ("7"), hex_timer[1] blank; timer = 8'd42 → "42".
- Defaults, timer = 8'd255, NUM_DIGITS = 2 → saturates to "99"; change timer to 30 mid-SHIFT → "99" shown, then "30" within 21 cycles, never a mixed digit pair.
- FLASH_CYCLES = 4, enter ALERT → led all 1 for 4 cycles, all 0 for 4, repeat; leave to SET then re-enter → restarts with all-on phase; SET shows 10'b0101010101.
- ALERT_HEX_FLASH_EN defined, ALERT, held BCD = 5 → hex_timer[0] alternates "5"/blank in lock-step with led; undefined → blank throughout.
- rst_n pulsed low during SHIFT → bcd_busy drops same cycle, outputs at reset values, conversion of current timer restarts after release.
